// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: operand/result handshake bundle for seq_multiplier.
//   in_valid / in_ready    : operand request and acceptance (a, b, is_signed)
//   out_valid / out_ready  : result offer and consumption (product)
// master: the requester that supplies operands and consumes products.
// slave : the multiplier.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               is_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;

  modport master (
    output in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier, one partial product per clock.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   seq_multiplier_if slave: operands in (a, b, is_signed), product out
//   busy  high while iterating
// Latency is exactly WIDTH cycles from acceptance to out_valid, independent of data.
// Signed operands are converted to magnitudes on acceptance; the sign is re-applied
// on the final iteration.
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  seq_multiplier_if.slave bus,
  output logic            busy
);
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;     // multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0] mplier_q, mplier_d;   // multiplier magnitude, shifted right each step
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    // Negating the most-negative value gives 2^(WIDTH-1), which is correct as unsigned.
    a_mag = (bus.is_signed && bus.a[WIDTH-1]) ? (WIDTH'(0) - bus.a) : bus.a;
    b_mag = (bus.is_signed && bus.b[WIDTH-1]) ? (WIDTH'(0) - bus.b) : bus.b;
    sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastIter) begin
          product_d = neg_q ? (PW'(0) - sum) : sum;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decode state only; no input reaches them combinationally.
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign busy          = (state_q == StBusy);
  assign bus.product   = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: self-checking bench for seq_multiplier at WIDTH=4 (lane 0)
// and WIDTH=8 (lane 1). Directed cases, backpressure, mid-operation reset, then a
// randomised regression on both lanes concurrently against an arithmetic reference.
module tb_seq_multiplier;
  logic clk = 1'b0;
  logic rst;
  logic busy4, busy8;
  int   checks = 0;
  int   errs = 0;

  seq_multiplier_if #(.WIDTH(4)) bus4 ();
  seq_multiplier_if #(.WIDTH(8)) bus8 ();

  seq_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .busy(busy4));
  seq_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8), .busy(busy8));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int l, input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic s);
    if (l == 0) begin
      bus4.in_valid = v; bus4.a = a[3:0]; bus4.b = b[3:0]; bus4.is_signed = s;
    end else begin
      bus8.in_valid = v; bus8.a = a; bus8.b = b; bus8.is_signed = s;
    end
  endtask

  task automatic set_ordy(input int l, input logic r);
    if (l == 0) bus4.out_ready = r;
    else        bus8.out_ready = r;
  endtask

  function automatic logic rdy(input int l);
    return (l == 0) ? bus4.in_ready : bus8.in_ready;
  endfunction

  function automatic logic ovld(input int l);
    return (l == 0) ? bus4.out_valid : bus8.out_valid;
  endfunction

  function automatic logic bsy(input int l);
    return (l == 0) ? busy4 : busy8;
  endfunction

  function automatic logic [15:0] prod(input int l);
    return (l == 0) ? {8'h00, bus4.product} : bus8.product;
  endfunction

  // Reference: interpret operands as w-bit signed/unsigned integers and multiply.
  function automatic logic [15:0] ref_mul(input int w, input logic s, input logic [7:0] a,
                                          input logic [7:0] b);
    longint av, bv, m;
    av = longint'(a) & ((longint'(1) << w) - 1);
    bv = longint'(b) & ((longint'(1) << w) - 1);
    if (s && av >= (longint'(1) << (w - 1))) av -= longint'(1) << w;
    if (s && bv >= (longint'(1) << (w - 1))) bv -= longint'(1) << w;
    m = (av * bv) & ((longint'(1) << (2 * w)) - 1);
    return 16'(m);
  endfunction

  // Called just after acceptance; returns cycles until out_valid and count of bad flags.
  task automatic wait_done(input int l, output int lat, output int bad);
    lat = 0;
    bad = 0;
    while (!ovld(l) && lat < 40) begin
      if (rdy(l) || !bsy(l)) bad++;
      step();
      lat++;
    end
    if (rdy(l) || bsy(l)) bad++;
  endtask

  task automatic run_op(input int l, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input string tag);
    int lat, bad;
    check({tag, " ready"}, rdy(l), 1);
    set_in(l, 1'b1, a, b, s);
    step();
    // Operand changes after acceptance must not matter.
    set_in(l, 1'b0, ~a, ~b, ~s);
    wait_done(l, lat, bad);
    check({tag, " latency"}, lat, (l == 0) ? 4 : 8);
    check({tag, " flags"}, bad, 0);
    check({tag, " product"}, prod(l), exp);
    set_ordy(l, 1'b1);
    step();
    set_ordy(l, 1'b0);
    check({tag, " idle"}, {ovld(l), rdy(l)}, 2'b01);
  endtask

  task automatic rand_lane(input int l, input int nops);
    logic [15:0] q[$];
    logic [15:0] e;
    logic        iv, ordy, s;
    logic [7:0]  a, b;
    int          w, acc, got, extra, cyc;
    w = (l == 0) ? 4 : 8;
    acc = 0; got = 0; extra = 0; cyc = 0;
    while ((acc < nops || got < nops) && cyc < nops * 30) begin
      iv   = (acc < nops) && ($urandom_range(0, 3) != 0);
      a    = 8'($urandom);
      b    = 8'($urandom);
      s    = acc[0];
      ordy = ($urandom_range(0, 3) != 0);
      set_in(l, iv, a, b, s);
      set_ordy(l, ordy);
      if (iv && rdy(l)) begin
        q.push_back(ref_mul(w, s, a, b));
        acc++;
      end
      if (ordy && ovld(l)) begin
        if (q.size() == 0) begin
          extra++;
        end else begin
          e = q.pop_front();
          check($sformatf("rnd w=%0d op %0d", w, got), prod(l), e);
          got++;
        end
      end
      step();
      cyc++;
    end
    set_in(l, 1'b0, 8'h00, 8'h00, 1'b0);
    set_ordy(l, 1'b0);
    check($sformatf("rnd w=%0d accepted", w), acc, nops);
    check($sformatf("rnd w=%0d completed", w), got, nops);
    check($sformatf("rnd w=%0d spurious", w), extra, 0);
  endtask

  initial begin
    int lat, bad;
    rst = 1'b1;
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
    set_ordy(0, 1'b0);
    set_ordy(1, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    for (int l = 0; l < 2; l++) begin
      check($sformatf("reset l%0d in_ready", l), rdy(l), 1);
      check($sformatf("reset l%0d out_valid", l), ovld(l), 0);
      check($sformatf("reset l%0d busy", l), bsy(l), 0);
      check($sformatf("reset l%0d product", l), prod(l), 0);
    end

    run_op(0, 1'b0, 8'd15, 8'd15, 16'h00E1, "w4 u 15x15");
    run_op(0, 1'b1, 8'h08, 8'h08, 16'h0040, "w4 s -8x-8");
    run_op(0, 1'b1, 8'h0D, 8'h05, 16'h00F1, "w4 s -3x5");
    run_op(0, 1'b1, 8'h07, 8'h00, 16'h0000, "w4 s 7x0");
    run_op(1, 1'b0, 8'hFF, 8'hFF, 16'hFE01, "w8 u 255x255");
    run_op(1, 1'b1, 8'h80, 8'h7F, 16'hC080, "w8 s -128x127");
    run_op(1, 1'b1, 8'h80, 8'h80, 16'h4000, "w8 s -128x-128");

    // Product holds in IDLE, then a reset during the second iteration aborts the op.
    run_op(0, 1'b0, 8'd15, 8'd15, 16'h00E1, "w4 pre-reset");
    repeat (2) step();
    check("idle hold product", prod(0), 16'h00E1);
    set_in(0, 1'b1, 8'd3, 8'd5, 1'b0);
    step();
    set_in(0, 1'b0, 8'd0, 8'd0, 1'b0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst in_ready", rdy(0), 1);
    check("midrst out_valid", ovld(0), 0);
    check("midrst busy", bsy(0), 0);
    check("midrst product", prod(0), 0);
    run_op(0, 1'b0, 8'd6, 8'd7, 16'h002A, "w4 after reset 6x7");

    // Backpressure on the WIDTH=8 lane.
    set_in(1, 1'b1, 8'h80, 8'h80, 1'b1);
    step();
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
    wait_done(1, lat, bad);
    check("bp latency", lat, 8);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!ovld(1) || bsy(1) || rdy(1) || prod(1) !== 16'h4000) bad++;
      set_in(1, (i == 3), 8'h06, 8'h07, 1'b0);
      step();
    end
    check("bp hold", bad, 0);
    check("bp product", prod(1), 16'h4000);
    check("bp out_valid", ovld(1), 1);
    set_ordy(1, 1'b1);
    step();
    set_ordy(1, 1'b0);
    check("bp ready after consume", rdy(1), 1);
    set_in(1, 1'b1, 8'd6, 8'd7, 1'b0);
    step();
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0);
    check("bp next accept", bsy(1), 1);
    wait_done(1, lat, bad);
    check("bp next latency", lat, 8);
    check("bp next product", prod(1), 16'h002A);
    set_ordy(1, 1'b1);
    step();
    set_ordy(1, 1'b0);

    fork
      rand_lane(0, 4000);
      rand_lane(1, 4000);
    join

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
